totp_truncate: RTL and testbench
================================

# totp_truncate

Bit-serial dynamic-truncation back end of the TOTP engine. It consumes the 160-bit final HMAC-SHA1 digest as a serial stream from the outer-hash stage, downstream of the HMAC message mixer and SHA-1 core. It applies RFC 4226 dynamic truncation and reduces the result modulo 10^6. The result is presented as six BCD digits to the display/readout logic.

## Interface
Parameters: none.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse that begins a new digest capture. It aborts any operation in progress.
- `bit_valid` input 1: `bit_in` carries a digest bit this cycle.
- `bit_in` input 1: digest bit. Order is MSB first: byte 0 bit 7 first, byte 19 bit 0 last.
- `busy` output 1: high from the cycle after `start` until `done` rises.
- `done` output 1: level. High while `code` is valid; held until the next `start`.
- `code` output 32: the result (format set by configuration). Holds its value until the next `done` rise or reset.

## Operation
- States: IDLE, LOAD, EXTRACT, MOD, CONV, DONE.
- IDLE: wait for `start`.
- `start` in any state:
  - go to LOAD, clear the 8-bit bit counter, `done`=0, `busy`=1.
  - `code` keeps its old value.
- LOAD:
  - each `bit_valid` cycle shifts `bit_in` into a 160-bit register and increments the counter.
  - accepting bit 160 (counter 159) moves to EXTRACT on the next edge.
  - bits beyond 160, and `bit_valid` in any state other than LOAD, are ignored.
- EXTRACT (1 cycle):
  - offset = low nibble of byte 19.
  - v = bytes[offset..offset+3] big-endian, with bit 31 cleared.
  - offset 15 uses bytes 15..18.
- MOD (12 cycles, k = 11 down to 0): if r >= 1_000_000<<k then r -= 1_000_000<<k.
  - r is 31 bits wide; 1_000_000<<11 = 2_048_000_000 fits.
  - after the last step, r < 1_000_000 (20 bits).
- CONV (20 cycles): double-dabble of the 20-bit r into 24-bit BCD.
  - before each shift, add 3 to every nibble that is >= 5.
- DONE:
  - `code` = {8'h00, BCD}; `done`=1, `busy`=0.
  - stay in DONE until `start`.
- Reset: state IDLE, `code`=0, `done`=0, `busy`=0. The shift register and counter are cleared.
- Reset asserted mid-operation discards the operation with no partial output.

## Timing
- `start` is sampled at edge E0. LOAD is active from E0+1; bits are accepted on any later edge with `bit_valid`=1.
- `bit_valid` may be deasserted for any number of cycles inside LOAD.
- The 160th bit is accepted at edge E1. Then:
  - EXTRACT at E1+1.
  - MOD covers E1+2..E1+13.
  - CONV covers E1+14..E1+33.
  - `done`=1 and `code` valid after E1+34, i.e. latency is 34 cycles.
- `start` coincident with `bit_valid`: the restart wins and that bit is dropped.
- `start` coincident with entry into DONE: the restart wins, `done` stays 0 and `code` is not updated.

## Configuration
- `TOTP_BCD_EN` defined:
  - behaviour is exactly as above; `code` = {8'h00, six BCD digits}.
  - `code` is nonzero only in bits [23:0].
- `TOTP_BCD_EN` undefined:
  - the MOD and CONV states and their datapath are not built.
  - DONE follows EXTRACT directly; latency after the 160th bit is 2 cycles.
  - `code` = {1'b0, v[30:0]}, the raw truncated value; the host performs the modulo.

## Test plan
1. RFC 4226 vector, counter 0: digest cc93cf18508d94934c64b65d8ba7667fb7cde4b0 with continuous `bit_valid`.
   - Required: offset 0, v=0x4C93CF18.
   - `code`=0x00755224 (no-BCD build: 0x4C93CF18).
   - `done` exactly 34 cycles after the last bit.
2. RFC 4226 §5.4 digest 1f8698690e02ca16618550ef7f19da8e945b555a with random `bit_valid` gaps.
   - Required: offset 10, v=0x50EF7F19, `code`=0x00872921.
3. All-ones digest.
   - Required: offset 15, bytes 15..18, v=0x7FFFFFFF, `code`=0x00483647.
4. All-zero digest.
   - Required: `code`=0x00000000, `done`=1.
5. Abort: `start` after 80 bits, then the vector from scenario 1 in full.
   - Required: result 0x00755224, with `busy` continuous throughout.
6. Reset during MOD.
   - Required: `done`=0, `busy`=0, `code`=0 immediately and asynchronously.
   - A following `start` plus the vector from scenario 2 yields 0x00872921.
   - Extra `bit_valid` pulses sent while in DONE leave `code` unchanged.

Source files
------------

// File: rtl/totp_truncate.sv
// ============================================================================
// Module   : totp_truncate
// Purpose  : Bit-serial RFC 4226 dynamic truncation of a 160-bit HMAC-SHA1
//            digest, optionally reduced mod 10^6 and converted to 6 BCD digits
//            (enabled by defining TOTP_BCD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module totp_truncate (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] code
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_EXTRACT = 3'd2,
        S_MOD     = 3'd3,
        S_CONV    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] C_LAST_BIT = 8'd159;

    state_t        r_state;
    logic [159:0]  r_shreg;
    logic [7:0]    r_cnt;
    logic [30:0]   r_rem;

    // Byte 19's low nibble picks the first of four big-endian bytes; bit 31 is dropped.
    logic [7:0]    w_base;
    logic [30:0]   w_v;

    assign w_base = 8'd158 - {1'b0, r_shreg[3:0], 3'b000};
    assign w_v    = r_shreg[w_base -: 31];

`ifdef TOTP_BCD_EN
    localparam logic [30:0] C_MODULUS = 31'd1_000_000;

    logic [23:0]   r_bcd;
    logic [30:0]   w_sub;
    logic [23:0]   w_adj;

    assign w_sub = C_MODULUS << r_cnt[3:0];

    generate
        for (genvar i = 0; i < 6; i++) begin : g_adj
            assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                     (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
        end
    endgenerate
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
`ifdef TOTP_BCD_EN
            r_bcd   <= '0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
            code    <= '0;
        end else if (start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (bit_valid) begin
                        r_shreg <= {r_shreg[158:0], bit_in};
                        if (r_cnt == C_LAST_BIT) begin
                            r_state <= S_EXTRACT;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_EXTRACT: begin
                    r_rem <= w_v;
`ifdef TOTP_BCD_EN
                    r_cnt   <= 8'd11;
                    r_bcd   <= '0;
                    r_state <= S_MOD;
`else
                    r_state <= S_DONE;
`endif
                end
`ifdef TOTP_BCD_EN
                // Restoring reduction: subtract 10^6 * 2^k for k = 11 .. 0.
                S_MOD: begin
                    if (r_rem >= w_sub) begin
                        r_rem <= r_rem - w_sub;
                    end
                    if (r_cnt == 8'd0) begin
                        r_cnt   <= 8'd19;
                        r_state <= S_CONV;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_CONV: begin
                    r_bcd <= {w_adj[22:0], r_rem[19]};
                    r_rem <= {r_rem[29:0], 1'b0};
                    if (r_cnt == 8'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
`endif
                S_DONE: begin
                    if (!done) begin
                        done <= 1'b1;
                        busy <= 1'b0;
`ifdef TOTP_BCD_EN
                        code <= {8'h00, r_bcd};
`else
                        code <= {1'b0, r_rem};
`endif
                    end
                end
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_totp_truncate.sv
// ============================================================================
// Module   : tb_totp_truncate
// Purpose  : Directed self-checking bench for totp_truncate (both builds,
//            selected by TOTP_BCD_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_totp_truncate;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] code;

    int n_cmp = 0;
    int n_err = 0;
    bit mon = 1'b0;
    bit busy_gap = 1'b0;

    localparam logic [159:0] C_V1 = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;
    localparam logic [159:0] C_V2 = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
    localparam logic [159:0] C_ONES = {160{1'b1}};
    localparam logic [159:0] C_ZERO = 160'd0;

`ifdef TOTP_BCD_EN
    localparam logic [31:0] C_EXP1 = 32'h0075_5224;
    localparam logic [31:0] C_EXP2 = 32'h0087_2921;
    localparam logic [31:0] C_EXP3 = 32'h0048_3647;
    localparam int          C_LAT  = 34;
`else
    localparam logic [31:0] C_EXP1 = 32'h4C93_CF18;
    localparam logic [31:0] C_EXP2 = 32'h50EF_7F19;
    localparam logic [31:0] C_EXP3 = 32'h7FFF_FFFF;
    localparam int          C_LAT  = 2;
`endif

    always #5 clk = ~clk;

    totp_truncate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .done      (done),
        .code      (code)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic watch();
        if (mon && busy !== 1'b1) busy_gap = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic feed(input logic [159:0] d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    bit_valid = 1'b0;
                    @(negedge clk);
                    watch();
                end
            end
            bit_valid = 1'b1;
            bit_in    = d[159-i];
            @(negedge clk);
            watch();
        end
        bit_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (done !== 1'b1 && l < 200) begin
            @(negedge clk);
            l++;
            if (done !== 1'b1) watch();
        end
    endtask

    task automatic run(input logic [159:0] d, input bit gaps, output logic [31:0] c, output int l);
        pulse_start();
        feed(d, 160, gaps);
        wait_done(l);
        c = code;
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] held;
        int          l;

        repeat (3) @(negedge clk);
        check_eq("rst_code", code, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // RFC 4226 counter 0, continuous stream
        run(C_V1, 1'b0, c, l);
        check_eq("v1_code", c, C_EXP1);
        check_eq("v1_latency", l, C_LAT);
        check_eq("v1_busy_low", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("v1_done_held", {31'd0, done}, 32'd1);

        // bit_valid with random gaps
        run(C_V2, 1'b1, c, l);
        check_eq("v2_code", c, C_EXP2);
        check_eq("v2_latency", l, C_LAT);

        // offset 15 corner
        run(C_ONES, 1'b0, c, l);
        check_eq("ones_code", c, C_EXP3);

        run(C_ZERO, 1'b0, c, l);
        check_eq("zero_code", c, 32'd0);
        check_eq("zero_done", {31'd0, done}, 32'd1);

        // abort after 80 bits, then a complete capture
        pulse_start();
        mon = 1'b1;
        busy_gap = 1'b0;
        feed(C_ONES, 80, 1'b0);
        run(C_V1, 1'b0, c, l);
        mon = 1'b0;
        check_eq("abort_code", c, C_EXP1);
        check_eq("abort_busy_gap", {31'd0, busy_gap}, 32'd0);

        // asynchronous reset mid-computation
        pulse_start();
        feed(C_V2, 160, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_done", {31'd0, done}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_code", code, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run(C_V2, 1'b0, c, l);
        check_eq("post_rst_code", c, C_EXP2);

        // stray bits in DONE are ignored
        held = code;
        repeat (6) begin
            bit_valid = 1'b1;
            bit_in    = ~bit_in;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        @(negedge clk);
        check_eq("done_ignore_code", code, C_EXP2);
        check_eq("done_ignore_held", code, held);
        check_eq("done_ignore_done", {31'd0, done}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
